// File: rtl/shift_mlp_engine.sv
// rtl/shift_mlp_engine.sv - shift-weight spiking MLP inference engine; define SHIFT_MLP_SAT_EN for saturating arithmetic
module shift_mlp_engine #(
    parameter int N_CH   = 2,
    parameter int N_OUT  = 2,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 8,
    parameter logic [ACC_W-1:0] TH = ACC_W'(1),
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*N_CH-1:0]   in_vec,
    output logic                w_req,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic                w_valid,
    input  logic [7:0]          w_data,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    pred_idx,
    output logic [ACC_W-1:0]    pred_score
);

    localparam int F    = N_CH * N_OUT / 2;
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
`ifdef SHIFT_MLP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, L1, FETCH, ARGMAX, DONE} state_t;
    state_t state, state_nxt;

    logic [8*N_CH-1:0] in_lat;
    logic [ACC_W-1:0]  l1_sum [N_CH];
    logic [ACC_W-1:0]  sum [N_CH];
    logic [N_CH-1:0]   spike;
    logic [ACC_W-1:0]  acc [N_OUT];
    logic [ACC_W-1:0]  acc_nxt [N_OUT];
    logic [CH_W-1:0]   w_ch, ch_lo, ch_nxt;
    logic [IDX_W-1:0]  w_out, out_lo, out_nxt;
    logic [ACC_W-1:0]  term_hi, term_lo;
    logic [IDX_W-1:0]  scan_idx, best_idx, sel_idx;
    logic [ACC_W-1:0]  best_val, sel_val;
    logic              last_byte, scan_last;

    // Overflowed values either clamp to all-ones or wrap, depending on build
    function automatic logic [ACC_W-1:0] fit(input logic [ACC_W+8:0] v);
        return (SAT && (|v[ACC_W+8:ACC_W])) ? ACC_MAX : v[ACC_W-1:0];
    endfunction

    // Signed 4-bit weight is a shift count: left for positive, right for negative
    function automatic logic [ACC_W-1:0] shift_term(input logic [ACC_W-1:0] x, input logic [3:0] s);
        logic [ACC_W+7:0] wide;
        logic [3:0]       mag;
        wide = {8'd0, x};
        mag  = 4'd0 - s;
        if (!s[3])
            wide = wide << s[2:0];
        else
            wide = wide >> mag;
        return fit({1'b0, wide});
    endfunction

    function automatic logic [ACC_W-1:0] add_acc(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] t);
        return fit({9'd0, a} + {9'd0, t});
    endfunction

    assign last_byte = (w_addr == ADDR_W'(F - 1));
    assign scan_last = (scan_idx == IDX_W'(N_OUT - 1));

    // Layer-1 nibble sums of the latched input vector
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            l1_sum[i] = ACC_W'(in_lat[8*i+4 +: 4]) + ACC_W'(in_lat[8*i +: 4]);
        end
    end

    // Weight-pair decode: destinations of the hi/lo nibbles and the updated accumulators
    always_comb begin
        out_lo  = (w_out == IDX_W'(N_OUT - 1)) ? '0 : w_out + 1'b1;
        ch_lo   = (w_out == IDX_W'(N_OUT - 1)) ? w_ch + 1'b1 : w_ch;
        out_nxt = (out_lo == IDX_W'(N_OUT - 1)) ? '0 : out_lo + 1'b1;
        ch_nxt  = (out_lo == IDX_W'(N_OUT - 1)) ? ch_lo + 1'b1 : ch_lo;
        term_hi = shift_term(sum[w_ch], w_data[7:4]);
        term_lo = shift_term(sum[ch_lo], w_data[3:0]);
        for (int j = 0; j < N_OUT; j++) begin
            acc_nxt[j] = acc[j];
            if (spike[w_ch] && (w_out == IDX_W'(j)))
                acc_nxt[j] = add_acc(acc_nxt[j], term_hi);
            if (spike[ch_lo] && (out_lo == IDX_W'(j)))
                acc_nxt[j] = add_acc(acc_nxt[j], term_lo);
        end
    end

    // Argmax step: first entry always taken, later ones only if strictly greater
    always_comb begin
        sel_idx = best_idx;
        sel_val = best_val;
        if ((scan_idx == '0) || (acc[scan_idx] > best_val)) begin
            sel_idx = scan_idx;
            sel_val = acc[scan_idx];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        w_req     = (state == FETCH);
        case (state)
            IDLE:    if (start) state_nxt = L1;
            L1:      state_nxt = FETCH;
            FETCH:   if (w_valid && last_byte) state_nxt = ARGMAX;
            ARGMAX:  if (scan_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: input latch, layer-1 spikes, weight accumulation, argmax scan, result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_lat     <= '0;
            spike      <= '0;
            w_addr     <= '0;
            w_ch       <= '0;
            w_out      <= '0;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_val   <= '0;
            pred_idx   <= '0;
            pred_score <= '0;
            done       <= 1'b0;
            for (int i = 0; i < N_CH; i++) sum[i] <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: if (start) in_lat <= in_vec;
                L1: begin
                    for (int i = 0; i < N_CH; i++) begin
                        sum[i]   <= l1_sum[i];
                        spike[i] <= (l1_sum[i] > TH);
                    end
                    for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
                    w_addr   <= '0;
                    w_ch     <= '0;
                    w_out    <= '0;
                    scan_idx <= '0;
                end
                FETCH: if (w_valid) begin
                    for (int j = 0; j < N_OUT; j++) acc[j] <= acc_nxt[j];
                    w_addr <= w_addr + 1'b1;
                    w_ch   <= ch_nxt;
                    w_out  <= out_nxt;
                end
                ARGMAX: begin
                    best_idx <= sel_idx;
                    best_val <= sel_val;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_last) begin
                        pred_idx   <= sel_idx;
                        pred_score <= sel_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_mlp_engine.sv
// tb/tb_shift_mlp_engine.sv - self-checking bench for shift_mlp_engine with behavioural model
module tb_shift_mlp_engine;

    localparam int N_CH  = 2;
    localparam int N_OUT = 2;
    localparam int F     = N_CH * N_OUT / 2;
    localparam int TH    = 1;
    localparam int MAXV  = 255;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in_vec;
    logic        w_req;
    logic [3:0]  w_addr;
    logic        w_valid;
    logic [7:0]  w_data;
    logic        busy;
    logic        done;
    logic [0:0]  pred_idx;
    logic [7:0]  pred_score;

    shift_mlp_engine #(
        .N_CH(N_CH), .N_OUT(N_OUT), .ADDR_W(4), .ACC_W(8), .TH(8'd1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec),
        .w_req(w_req), .w_addr(w_addr), .w_valid(w_valid), .w_data(w_data),
        .busy(busy), .done(done), .pred_idx(pred_idx), .pred_score(pred_score)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mem [16];
    int m_acc [N_OUT];
    int exp_idx [256];
    int exp_score [256];
    int run_cnt = 0;
    int wait_mode = 0;
    int nbytes = 0;
    int tot_wait = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    function automatic int fitv(input int v);
`ifdef SHIFT_MLP_SAT_EN
        return (v > MAXV) ? MAXV : v;
`else
        return v % (MAXV + 1);
`endif
    endfunction

    // Reference: per-weight arithmetic straight from the mapping rules
    function automatic void model(input logic [15:0] vin, output int idx, output int score);
        int nib, s, sm, t, ch, oj;
        logic [7:0] b;
        for (int q = 0; q < N_OUT; q++) m_acc[q] = 0;
        for (int k = 0; k < 2 * F; k++) begin
            b   = mem[k / 2];
            nib = (k % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]);
            s   = (nib >= 8) ? nib - 16 : nib;
            ch  = k / N_OUT;
            oj  = k % N_OUT;
            sm  = int'(vin[8*ch+4 +: 4]) + int'(vin[8*ch +: 4]);
            if (sm > TH) begin
                t = (s >= 0) ? sm * (1 << s) : sm / (1 << (-s));
                m_acc[oj] = fitv(m_acc[oj] + fitv(t));
            end
        end
        idx = 0;
        score = m_acc[0];
        for (int q = 1; q < N_OUT; q++) begin
            if (m_acc[q] > score) begin
                idx = q;
                score = m_acc[q];
            end
        end
    endfunction

    // Weight memory responder with per-request latency; w_valid is noise while w_req is low
    initial begin
        int wcnt;
        int cur_wait;
        bit drove;
        wcnt = 0; cur_wait = 0; drove = 0;
        w_valid = 1'b0;
        w_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!busy) begin
                nbytes = 0;
                wcnt = 0;
                cur_wait = (wait_mode < 0) ? $urandom_range(0, 3) : wait_mode;
            end
            if (w_req) begin
                if (wcnt >= cur_wait) begin
                    w_valid = 1'b1;
                    w_data = mem[w_addr];
                    drove = 1;
                end else begin
                    w_valid = 1'b0;
                    w_data = 8'($urandom);
                    wcnt++;
                    tot_wait++;
                end
            end else begin
                w_valid = 1'($urandom);
                w_data = 8'($urandom);
            end
            @(posedge clk);
            #1;
            if (drove) begin
                nbytes++;
                wcnt = 0;
                cur_wait = (wait_mode < 0) ? $urandom_range(0, 3) : wait_mode;
                drove = 0;
            end
        end
    end

    // Cycle-by-cycle compare against the expected results queue and held prediction
    initial begin
        int held_idx, held_score, done_cnt;
        bit prev_done;
        held_idx = 0; held_score = 0; done_cnt = 0; prev_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_idx = 0;
                held_score = 0;
                check("reset pred_idx", pred_idx, 0);
                check("reset pred_score", pred_score, 0);
                check("reset done", done, 0);
                check("reset busy", busy, 0);
            end else begin
                if (done) begin
                    check("done while idle", busy, 0);
                    check("done single cycle", prev_done, 0);
                    check("done pred_idx", pred_idx, exp_idx[done_cnt % 256]);
                    check("done pred_score", pred_score, exp_score[done_cnt % 256]);
                    held_idx = exp_idx[done_cnt % 256];
                    held_score = exp_score[done_cnt % 256];
                    done_cnt++;
                end else if (!busy) begin
                    check("held pred_idx", pred_idx, held_idx);
                    check("held pred_score", pred_score, held_score);
                end
                if (w_req) check("w_addr tracks accepted bytes", w_addr, nbytes);
            end
            prev_done = done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_done(input string tag, output int edges);
        bit got;
        edges = 0;
        got = 0;
        while (!got && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) got = 1;
        end
        check({tag, " done seen"}, got, 1);
    endtask

    task automatic run_inf(input logic [15:0] vin, input int wm, input string tag);
        int mi, ms, edges, tw0;
        model(vin, mi, ms);
        exp_idx[run_cnt % 256] = mi;
        exp_score[run_cnt % 256] = ms;
        wait_mode = wm;
        @(negedge clk);
        @(negedge clk);
        in_vec = vin;
        start = 1'b1;
        tw0 = tot_wait;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_vec = 16'($urandom);
        wait_done(tag, edges);
        check({tag, " latency"}, edges, F + N_OUT + 2 + (tot_wait - tw0));
        check({tag, " pred_idx"}, pred_idx, mi);
        check({tag, " pred_score"}, pred_score, ms);
        run_cnt++;
    endtask

    initial begin
        int mi, ms, edges, nd;
        rst_n = 1'b0;
        start = 1'b0;
        in_vec = 16'h0000;
        for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);

        @(negedge clk);
        #1;
        check("rst w_req", w_req, 0);
        check("rst w_addr", w_addr, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pred_idx", pred_idx, 0);
        check("rst pred_score", pred_score, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Hand-computed values pinning the model
        mem[0] = 8'h10; mem[1] = 8'hF2;
        model(16'h1122, mi, ms);
        check("model acc0", m_acc[0], 9);
        check("model acc1", m_acc[1], 12);
        check("model idx", mi, 1);
        check("model score", ms, 12);
        mem[0] = 8'h30; mem[1] = 8'h30;
        model(16'hFFFF, mi, ms);
        check("model sat idx", mi, 0);
`ifdef SHIFT_MLP_SAT_EN
        check("model sat score", ms, 255);
`else
        check("model wrap score", ms, 224);
`endif

        // Basic inference, zero wait
        mem[0] = 8'h10; mem[1] = 8'hF2;
        run_inf(16'h1122, 0, "basic");
        check("basic literal idx", pred_idx, 1);
        check("basic literal score", pred_score, 12);

        // Overflow behaviour
        mem[0] = 8'h30; mem[1] = 8'h30;
        run_inf(16'hFFFF, 0, "overflow");
        check("overflow literal idx", pred_idx, 0);
`ifdef SHIFT_MLP_SAT_EN
        check("overflow literal score", pred_score, 255);
`else
        check("overflow literal score", pred_score, 224);
`endif

        // No spikes: all-zero tie resolves to index 0
        mem[0] = 8'($urandom); mem[1] = 8'($urandom);
        run_inf(16'h0001, -1, "nospike");
        check("nospike literal idx", pred_idx, 0);
        check("nospike literal score", pred_score, 0);

        // Slow memory, 3 wait cycles per request
        mem[0] = 8'h10; mem[1] = 8'hF2;
        model(16'h1122, mi, ms);
        exp_idx[run_cnt % 256] = mi;
        exp_score[run_cnt % 256] = ms;
        wait_mode = 3;
        @(negedge clk);
        @(negedge clk);
        in_vec = 16'h1122;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("slow", edges);
        check("slow latency", edges, 12);
        check("slow literal idx", pred_idx, 1);
        check("slow literal score", pred_score, 12);
        run_cnt++;

        // Reset in the middle of the second fetch
        model(16'h1122, mi, ms);
        exp_idx[run_cnt % 256] = mi;
        exp_score[run_cnt % 256] = ms;
        wait_mode = 3;
        @(negedge clk);
        @(negedge clk);
        in_vec = 16'h1122;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (!(w_req && nbytes == 1) && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        check("abort reached second fetch", (w_req && nbytes == 1), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort w_req", w_req, 0);
        check("abort w_addr", w_addr, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort pred_idx", pred_idx, 0);
        check("abort pred_score", pred_score, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("abort no done", nd, 0);
        check("abort stays idle", busy, 0);
        run_inf(16'h1122, 0, "rerun");
        check("rerun literal idx", pred_idx, 1);
        check("rerun literal score", pred_score, 12);

        // Start held high: ignored while busy, restarts from idle
        model(16'h1122, mi, ms);
        exp_idx[run_cnt % 256] = mi;
        exp_score[run_cnt % 256] = ms;
        model(16'h0001, mi, ms);
        exp_idx[(run_cnt + 1) % 256] = mi;
        exp_score[(run_cnt + 1) % 256] = ms;
        wait_mode = 0;
        @(negedge clk);
        @(negedge clk);
        in_vec = 16'h1122;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_vec = 16'hFFFF;
        wait_done("held first", edges);
        check("held first latency", edges, 6);
        check("held first idx", pred_idx, 1);
        check("held first score", pred_score, 12);
        check("held idle at done", busy, 0);
        in_vec = 16'h0001;
        @(posedge clk);
        #1;
        check("held restart busy", busy, 1);
        wait_done("held second", edges);
        start = 1'b0;
        check("held second latency", edges, 6);
        check("held second idx", pred_idx, 0);
        check("held second score", pred_score, 0);
        run_cnt += 2;

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            logic [15:0] v;
            mem[0] = 8'($urandom);
            mem[1] = 8'($urandom);
            v = 16'($urandom);
            if (r % 5 == 0) v = v & 16'h1111;
            run_inf(v, -1, "random");
        end

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_mlp_engine.md
SHIFT_MLP_ENGINE -- requirements
Module: shift_mlp_engine

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of 8-bit input channels (>=1).
REQ-002 SHALL have parameter N_OUT, default 2: number of output neurons (>=2); N_CH*N_OUT SHALL be even.
REQ-003 SHALL have parameter ADDR_W, default 4: weight memory address width.
REQ-004 SHALL have parameter ACC_W, default 8: width of layer sums and accumulators (>=5).
REQ-005 SHALL have parameter TH, default 1: layer-1 spike threshold, ACC_W bits.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  begin inference; sampled only in IDLE.
REQ-009 in_vec  input  8*N_CH  channel i = in_vec[8i+7:8i].
REQ-010 w_req  output  1  weight read request.
REQ-011 w_addr  output  ADDR_W  weight byte address.
REQ-012 w_valid  input  1  w_data valid; ignored while w_req low.
REQ-013 w_data  input  8  two packed signed 4-bit weights.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 pred_idx  output  max(1,$clog2(N_OUT))  winning output index.
REQ-017 pred_score  output  ACC_W  winning accumulator value.

Function
REQ-018 FSM SHALL have states IDLE, L1, FETCH, ARGMAX, DONE. Transitions: IDLE->L1 on start; L1->FETCH; FETCH->FETCH per accepted byte, FETCH->ARGMAX after byte F-1, where F=N_CH*N_OUT/2; ARGMAX->DONE after N_OUT cycles; DONE->IDLE.
REQ-019 In IDLE with start high, in_vec SHALL be latched; start while busy SHALL be ignored.
REQ-020 L1: sum_i = hi nibble + lo nibble of channel i, zero-extended to ACC_W; spike_i = (sum_i > TH); all accumulators cleared.
REQ-021 Weight k (0..2F-1) maps to channel i=k/N_OUT, output j=k%N_OUT; byte address k/2 carries weight k in [7:4] and k+1 in [3:0].
REQ-022 In FETCH, w_req SHALL be high with w_addr stable at the current byte address until w_valid is sampled high; w_valid may arrive in the first request cycle (zero wait) or any later cycle.
REQ-023 On the accepting edge, both weights SHALL be applied: acc_j += spike_i ? shift(sum_i, w) : 0.
REQ-024 shift(x,s): s>=0 -> x<<s computed at ACC_W+8 bits; s<0 -> x>>|s|; s=-8 yields 0.
REQ-025 ARGMAX SHALL scan acc_0..acc_{N_OUT-1}, one per cycle, keeping strictly-greater candidates; ties resolve to the lowest index.
REQ-026 pred_idx/pred_score SHALL update on the edge entering DONE and hold until the next completed inference.
REQ-027 done SHALL be high for exactly the cycle following the DONE state; with zero-wait memory done is high after edge F+N_OUT+2, counting the start-sampling edge as 0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and clear w_req, w_addr, busy, done, pred_idx, pred_score, all accumulators, sums and latched inputs to 0, including mid-FETCH; no done pulse for the aborted run.

Configuration
REQ-029 With SHIFT_MLP_SAT_EN defined, shifted terms and accumulator sums exceeding 2^ACC_W-1 SHALL clamp to 2^ACC_W-1; without it they SHALL truncate modulo 2^ACC_W.

Verification
REQ-030 Defaults, in_vec=16'h1122, mem[0]=8'h10, mem[1]=8'hF2, zero wait -> acc0=9, acc1=12, pred_idx=1, pred_score=12, done after edge 6.
REQ-031 in_vec=16'hFFFF, mem[0]=8'h30, mem[1]=8'h30 -> pred_idx=0; pred_score=255 with SHIFT_MLP_SAT_EN, 224 without.
REQ-032 in_vec=16'h0001 (no spikes), any weights -> pred_idx=0, pred_score=0 (tie to lowest index).
REQ-033 w_valid delayed 3 cycles per request -> w_req and w_addr held stable throughout, same result as REQ-030, done 6 cycles later.
REQ-034 rst_n pulsed low during second FETCH -> all outputs 0 immediately, no done; subsequent start with REQ-030 stimulus gives REQ-030 result.
REQ-035 start held high continuously -> start ignored while busy; new run begins only after returning to IDLE.
